// File: rtl/fir_coe_loader.sv
// FIR coefficient loader: serial word stream into a shadow bank, atomic swap to active bank.
// Optional FIR_COE_CHECKSUM_EN: trailing XOR word per frame, verified before the swap.
module fir_coe_loader #(
  parameter int _COE_WIDTH = 16,
  parameter int _COE_NUM   = 17
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [_COE_WIDTH-1:0]          i_cfg_data,
  input  logic                           i_cfg_vld,
  input  logic                           i_cfg_last,
  output logic                           o_cfg_rdy,
  input  logic                           i_upd_allow,
  output logic [_COE_WIDTH*_COE_NUM-1:0] o_h_port,
  output logic                           o_h_upd,
  output logic                           o_err,
  output logic                           o_busy
);

`ifdef FIR_COE_CHECKSUM_EN
  localparam int FLEN = _COE_NUM + 1;
`else
  localparam int FLEN = _COE_NUM;
`endif
  localparam int CW = $clog2(_COE_NUM + 2);
  localparam int IW = (_COE_NUM > 1) ? $clog2(_COE_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DISCARD,
    WAIT_SWAP
  } state_e;

  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [_COE_NUM-1:0][_COE_WIDTH-1:0] shadow_q;
  logic [_COE_NUM-1:0][_COE_WIDTH-1:0] h_q;
  logic rdy_q;
  logic upd_q;
  logic err_q;
`ifdef FIR_COE_CHECKSUM_EN
  logic [_COE_WIDTH-1:0] csum_q;
`endif

  logic          acc;
  logic [CW-1:0] cnt_inc;
  logic          full;
  logic          wr_slot;

  assign acc     = i_cfg_vld & rdy_q;
  assign cnt_inc = cnt_q + CW'(1);
  assign full    = (cnt_inc == CW'(FLEN));
  assign wr_slot = (cnt_q < CW'(_COE_NUM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      h_q      <= '0;
      rdy_q    <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef FIR_COE_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      rdy_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            shadow_q[0] <= i_cfg_data;
            cnt_q       <= CW'(1);
`ifdef FIR_COE_CHECKSUM_EN
            csum_q      <= i_cfg_data;
`endif
            if (i_cfg_last) begin
              if (FLEN == 1) begin
                state_q <= WAIT_SWAP;
                rdy_q   <= 1'b0;
              end else begin
                err_q <= 1'b1;
                cnt_q <= '0;
              end
            end else if (FLEN == 1) begin
              state_q <= DISCARD;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            cnt_q <= cnt_inc;
            if (wr_slot) begin
              shadow_q[cnt_q[IW-1:0]] <= i_cfg_data;
`ifdef FIR_COE_CHECKSUM_EN
              csum_q <= csum_q ^ i_cfg_data;
`endif
            end
            if (i_cfg_last) begin
`ifdef FIR_COE_CHECKSUM_EN
              if (full && (csum_q == i_cfg_data)) begin
`else
              if (full) begin
`endif
                state_q <= WAIT_SWAP;
                rdy_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                err_q   <= 1'b1;
                cnt_q   <= '0;
              end
            end else if (full) begin
              state_q <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (acc && i_cfg_last) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        WAIT_SWAP: begin
          if (i_upd_allow) begin
            h_q     <= shadow_q;
            upd_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cfg_rdy = rdy_q;
  assign o_h_port  = h_q;
  assign o_h_upd   = upd_q;
  assign o_err     = err_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fir_coe_loader.sv
// Directed bench for fir_coe_loader: reset, swap timing, held swap, short/long frames.
// Follows FIR_COE_CHECKSUM_EN by appending the XOR word to every frame.
module tb_fir_coe_loader;
  localparam int W = 16;
  localparam int N = 17;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   data;
  logic           vld;
  logic           last;
  logic           rdy;
  logic           allow;
  logic [W*N-1:0] h;
  logic           upd;
  logic           err;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int upd_n = 0;
  int err_n = 0;
  int u0;
  int e0;

  fir_coe_loader #(
    ._COE_WIDTH(W),
    ._COE_NUM(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_cfg_data(data),
    .i_cfg_vld(vld),
    .i_cfg_last(last),
    .o_cfg_rdy(rdy),
    .i_upd_allow(allow),
    .o_h_port(h),
    .o_h_upd(upd),
    .o_err(err),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    upd_n <= upd_n + int'(upd);
    err_n <= err_n + int'(err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W*N-1:0] obs,
                     input logic [W*N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*N-1:0] mk(input logic [W-1:0] base);
    logic [W*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = base + W'(k + 1);
    return v;
  endfunction

  task automatic put(input logic [W-1:0] d, input logic l);
    vld  = 1'b1;
    data = d;
    last = l;
    tick();
    vld  = 1'b0;
    last = 1'b0;
    data = '0;
  endtask

  task automatic frame(input logic [W-1:0] base, input int n, input bit bad);
    logic [W-1:0] cs;
    logic [W-1:0] d;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      d = base + W'(i + 1);
      if (i < N) cs ^= d;
`ifdef FIR_COE_CHECKSUM_EN
      put(d, 1'b0);
`else
      put(d, i == n - 1);
`endif
    end
`ifdef FIR_COE_CHECKSUM_EN
    put(bad ? (cs ^ W'(3)) : cs, 1'b1);
`else
    if (bad) cs = '0;
`endif
  endtask

  initial begin
    reset = 1'b0;
    data  = '0;
    vld   = 1'b0;
    last  = 1'b0;
    allow = 1'b0;
    repeat (2) tick();
    chk("rst_rdy", W*N'(rdy), '0);
    chk("rst_h", h, '0);
    chk("rst_busy", W*N'(busy), '0);
    chk("rst_upd_err", W*N'({upd, err}), '0);

    reset = 1'b1;
    tick();
    chk("rel_rdy", W*N'(rdy), W*N'(1));
    put(16'hDEAD, 1'b0);
    put(16'hBEEF, 1'b0);
    put(16'hCAFE, 1'b0);
    chk("mid_busy", W*N'(busy), W*N'(1));

    reset = 1'b0;
    #1;
    chk("mid_rst_busy", W*N'(busy), '0);
    chk("mid_rst_rdy", W*N'(rdy), '0);
    chk("mid_rst_h", h, '0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel2_rdy", W*N'(rdy), W*N'(1));
    chk("rel2_busy", W*N'(busy), '0);

    // swap one cycle after the last accept when allowed
    allow = 1'b1;
    frame(16'h0000, N, 1'b0);
    chk("a_wait_upd", W*N'(upd), '0);
    chk("a_wait_rdy", W*N'(rdy), '0);
    chk("a_wait_h", h, '0);
    tick();
    chk("a_upd", W*N'(upd), W*N'(1));
    chk("a_h", h, mk(16'h0000));
    chk("a_slot0", W*N'(h[15:0]), W*N'(1));
    chk("a_slot16", W*N'(h[271:256]), W*N'(17));
    chk("a_busy", W*N'(busy), '0);
    tick();
    chk("a_upd_off", W*N'(upd), '0);

    // swap held off until allow rises
    allow = 1'b0;
    frame(16'h0100, N, 1'b0);
    repeat (10) tick();
    chk("b_hold_h", h, mk(16'h0000));
    chk("b_hold_rdy", W*N'(rdy), '0);
    chk("b_hold_busy", W*N'(busy), W*N'(1));
    chk("b_hold_upd", W*N'(upd), '0);
    allow = 1'b1;
    tick();
    chk("b_upd", W*N'(upd), W*N'(1));
    chk("b_h", h, mk(16'h0100));
    tick();

    // last without valid is ignored
    last = 1'b1;
    tick();
    last = 1'b0;
    chk("c_novld_err", W*N'(err), '0);
    chk("c_novld_busy", W*N'(busy), '0);

    u0 = upd_n;
    e0 = err_n;
    frame(16'hAAA0, 5, 1'b0);
    chk("c_short_err", W*N'(err), W*N'(1));
    chk("c_short_upd", W*N'(upd), '0);
    chk("c_short_busy", W*N'(busy), '0);
    chk("c_short_h", h, mk(16'h0100));
    tick();
    chk("c_err_off", W*N'(err), '0);

    frame(16'h5000, 20, 1'b0);
    chk("d_long_err", W*N'(err), W*N'(1));
    chk("d_long_h", h, mk(16'h0100));
    chk("d_long_rdy", W*N'(rdy), W*N'(1));
    chk("d_long_busy", W*N'(busy), '0);

    frame(16'h7000, N, 1'b0);
    chk("e_b2b_busy", W*N'(busy), W*N'(1));
    tick();
    chk("e_b2b_upd", W*N'(upd), W*N'(1));
    chk("e_b2b_h", h, mk(16'h7000));
    tick();
    chk("e_upd_count", W*N'(upd_n - u0), W*N'(1));
    chk("e_err_count", W*N'(err_n - e0), W*N'(2));

`ifdef FIR_COE_CHECKSUM_EN
    frame(16'h0000, N, 1'b1);
    chk("f_bad_err", W*N'(err), W*N'(1));
    chk("f_bad_upd", W*N'(upd), '0);
    chk("f_bad_h", h, mk(16'h7000));
    tick();
    frame(16'h0000, N, 1'b0);
    tick();
    chk("f_good_upd", W*N'(upd), W*N'(1));
    chk("f_good_h", h, mk(16'h0000));
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
